axis_fifo_pkt: RTL and testbench

//  Parametrised ready/valid (AXI-Stream style) FIFO with TLAST, fill level and almost-full/empty flags.

---
 rtl/axis_fifo_pkg.sv | 17 +
 rtl/axis_fifo_mem.sv | 32 +++
 rtl/axis_fifo_pkt.sv | 144 ++++++++++++++
 tb/tb_axis_fifo_pkt.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the packet-aware AXI-Stream FIFO.
//   cnt_w(depth) : width of a counter that must hold 0..depth inclusive
//   ptr_w(depth) : width of a pointer that indexes 0..depth-1
// The {last,data} beat struct depends on DATA_WIDTH, so it is declared inside
// axis_fifo_pkt. A package typedef cannot be parameterised by a module
// parameter.
package axis_fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Storage array for axis_fifo_pkt: DEPTH x WIDTH registers.
// The write is synchronous and the read is asynchronous, which gives
// first-word-fall-through output.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write index, 0..DEPTH-1
//   wdata_i : write word
//   raddr_i : read index, 0..DEPTH-1
//   rdata_o : word at raddr_i, combinational
// The contents are never reset.
module axis_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FIFO with TLAST, fill level, almost-full/almost-empty flags and an
// optional store-and-forward packet mode. DEPTH may be any value >= 2.
// Ports:
//   clk_i, rst_i          : clock and synchronous active-high reset
//   write_data_i, last_i  : slave beat payload
//   valid_i, ready_o      : slave handshake; ready_o = not full
//   read_data_o, last_o   : master beat payload, FWFT from the array
//   valid_o, ready_i      : master handshake
//   count_o               : entries stored
//   almost_full_o         : count_o >= AFULL_LEVEL
//   almost_empty_o        : count_o <= AEMPTY_LEVEL
//   pkt_count_o           : complete packets stored (TLAST beats held)
// Handshake: a beat moves on a posedge where valid and ready are both high.
// A source that raises valid keeps it and its payload stable until the beat is
// taken. Neither ready_o nor valid_o depends combinationally on the opposite
// side's valid/ready.
module axis_fifo_pkt
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int PACKET_MODE  = 0,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        write_data_i,
  input  logic                         last_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DATA_WIDTH-1:0]        read_data_o,
  output logic                         last_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit PKT = (PACKET_MODE != 0);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  if (DEPTH < 2) begin : g_bad_depth
    $error("axis_fifo_pkt: DEPTH must be >= 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("axis_fifo_pkt: AFULL_LEVEL must be in 1..DEPTH");
  end
  if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
    $error("axis_fifo_pkt: AEMPTY_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, pkt_count_q, pkt_count_d;
  logic          wr_en, rd_en, wr_last, rd_last;
  beat_t         wr_beat, rd_beat;

  // The pointer wraps explicitly, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  axis_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(beat_t)),
    .AW    (PW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_beat),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_beat)
  );

  assign wr_beat     = '{last: last_i, data: write_data_i};
  assign read_data_o = rd_beat.data;
  assign last_o      = rd_beat.last;

  // A full FIFO does not accept a write, even when a read happens in the same cycle.
  assign ready_o = (count_q != FULL_CNT);

  // Packet mode holds the output back until a whole packet is stored. If the
  // FIFO fills with no TLAST, it falls back to cut-through so that a packet
  // longer than DEPTH still drains.
  always_comb begin
    valid_o = (count_q != '0);
    if (PKT) valid_o = valid_o && ((pkt_count_q != '0) || (count_q == FULL_CNT));
  end

  assign wr_en   = valid_i & ready_o;
  assign rd_en   = valid_o & ready_i;
  assign wr_last = wr_en & last_i;
  assign rd_last = rd_en & rd_beat.last;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({wr_last, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + CW'(1);
      2'b01:   pkt_count_d = pkt_count_q - CW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // The flags come only from the registered count.
  assign count_o        = count_q;
  assign pkt_count_o    = pkt_count_q;
  assign almost_full_o  = (count_q >= CW'(AFULL_LEVEL));
  assign almost_empty_o = (count_q <= CW'(AEMPTY_LEVEL));

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Bench for axis_fifo_pkt. It uses three instances:
//   a : DEPTH 16, cut-through
//   b : DEPTH 5, cut-through
//   c : DEPTH 16, packet mode
module tb_axis_fifo_pkt;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // ---------------- instance a: DEPTH 16, cut-through ----------------
  logic [7:0] a_wdata, a_rdata;
  logic       a_wlast, a_wvalid, a_rready, a_ready_o, a_last_o, a_valid_o, a_af, a_ae;
  logic [4:0] a_count, a_pkt;
  logic [8:0] a_exp_q[$];
  int         a_cnt;

  axis_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(0), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) u_a (
    .clk_i(clk), .rst_i(rst), .write_data_i(a_wdata), .last_i(a_wlast), .valid_i(a_wvalid),
    .ready_o(a_ready_o), .read_data_o(a_rdata), .last_o(a_last_o), .valid_o(a_valid_o),
    .ready_i(a_rready), .count_o(a_count), .almost_full_o(a_af), .almost_empty_o(a_ae),
    .pkt_count_o(a_pkt));

  // ---------------- instance b: DEPTH 5, cut-through ----------------
  logic [7:0] b_wdata, b_rdata;
  logic       b_wlast, b_wvalid, b_rready, b_ready_o, b_last_o, b_valid_o, b_af, b_ae;
  logic [2:0] b_count, b_pkt;
  logic [8:0] b_exp_q[$];
  int         b_cnt, b_rcv;

  axis_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(5), .PACKET_MODE(0), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)) u_b (
    .clk_i(clk), .rst_i(rst), .write_data_i(b_wdata), .last_i(b_wlast), .valid_i(b_wvalid),
    .ready_o(b_ready_o), .read_data_o(b_rdata), .last_o(b_last_o), .valid_o(b_valid_o),
    .ready_i(b_rready), .count_o(b_count), .almost_full_o(b_af), .almost_empty_o(b_ae),
    .pkt_count_o(b_pkt));

  // ---------------- instance c: DEPTH 16, packet mode ----------------
  logic [7:0] c_wdata, c_rdata;
  logic       c_wlast, c_wvalid, c_rready, c_ready_o, c_last_o, c_valid_o, c_af, c_ae;
  logic [4:0] c_count, c_pkt;
  logic [8:0] c_exp_q[$];
  int         c_cnt, c_pcnt, c_rcv;

  axis_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(1), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) u_c (
    .clk_i(clk), .rst_i(rst), .write_data_i(c_wdata), .last_i(c_wlast), .valid_i(c_wvalid),
    .ready_o(c_ready_o), .read_data_o(c_rdata), .last_o(c_last_o), .valid_o(c_valid_o),
    .ready_i(c_rready), .count_o(c_count), .almost_full_o(c_af), .almost_empty_o(c_ae),
    .pkt_count_o(c_pkt));

  // ---------------- driver tasks ----------------
  // Each call covers one clock. The task drives the inputs, predicts the
  // handshake from the model, scores any read beat against the expected queue
  // and advances to 1 time unit after the next posedge.
  task automatic drive_a(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic exp_rdy, exp_vld, wr, rd;
    logic [8:0] exp;
    a_wvalid = v; a_wdata = d; a_wlast = l; a_rready = r;
    exp_rdy = (a_cnt != 16);
    exp_vld = (a_cnt != 0);
    checks++;
    if (a_ready_o !== exp_rdy) begin errors++; $display("FAIL a_ready: got %b expected %b", a_ready_o, exp_rdy); end
    checks++;
    if (a_valid_o !== exp_vld) begin errors++; $display("FAIL a_valid: got %b expected %b", a_valid_o, exp_vld); end
    wr = v && exp_rdy;
    rd = exp_vld && r;
    if (rd) begin
      checks++;
      if (a_exp_q.size() == 0) begin
        errors++; $display("FAIL a_data: got %h expected none", {a_last_o, a_rdata});
      end else begin
        exp = a_exp_q.pop_front();
        if ({a_last_o, a_rdata} !== exp) begin errors++; $display("FAIL a_data: got %h expected %h", {a_last_o, a_rdata}, exp); end
      end
    end
    if (wr) a_exp_q.push_back({l, d});
    a_cnt = a_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
    @(posedge clk); #1;
    checks++;
    if (a_count !== 5'(a_cnt)) begin errors++; $display("FAIL a_count: got %0d expected %0d", a_count, a_cnt); end
    checks++;
    if (a_af !== (a_cnt >= 14)) begin errors++; $display("FAIL a_afull: got %b at count %0d", a_af, a_cnt); end
    checks++;
    if (a_ae !== (a_cnt <= 2)) begin errors++; $display("FAIL a_aempty: got %b at count %0d", a_ae, a_cnt); end
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic l, input logic r, output logic wr);
    logic exp_rdy, exp_vld, rd;
    logic [8:0] exp;
    b_wvalid = v; b_wdata = d; b_wlast = l; b_rready = r;
    exp_rdy = (b_cnt != 5);
    exp_vld = (b_cnt != 0);
    checks++;
    if (b_ready_o !== exp_rdy) begin errors++; $display("FAIL b_ready: got %b expected %b", b_ready_o, exp_rdy); end
    checks++;
    if (b_valid_o !== exp_vld) begin errors++; $display("FAIL b_valid: got %b expected %b", b_valid_o, exp_vld); end
    wr = v && exp_rdy;
    rd = exp_vld && r;
    if (rd) begin
      b_rcv++;
      checks++;
      if (b_exp_q.size() == 0) begin
        errors++; $display("FAIL b_data: got %h expected none", {b_last_o, b_rdata});
      end else begin
        exp = b_exp_q.pop_front();
        if ({b_last_o, b_rdata} !== exp) begin errors++; $display("FAIL b_data: got %h expected %h", {b_last_o, b_rdata}, exp); end
      end
    end
    if (wr) b_exp_q.push_back({l, d});
    b_cnt = b_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
    @(posedge clk); #1;
    checks++;
    if (b_count !== 3'(b_cnt)) begin errors++; $display("FAIL b_count: got %0d expected %0d", b_count, b_cnt); end
  endtask

  task automatic drive_c(input logic v, input logic [7:0] d, input logic l, input logic r, output logic wr);
    logic exp_rdy, exp_vld, rd;
    logic [8:0] exp;
    c_wvalid = v; c_wdata = d; c_wlast = l; c_rready = r;
    exp_rdy = (c_cnt != 16);
    exp_vld = (c_cnt != 0) && ((c_pcnt != 0) || (c_cnt == 16));
    checks++;
    if (c_ready_o !== exp_rdy) begin errors++; $display("FAIL c_ready: got %b expected %b", c_ready_o, exp_rdy); end
    checks++;
    if (c_valid_o !== exp_vld) begin errors++; $display("FAIL c_valid: got %b expected %b at count %0d", c_valid_o, exp_vld, c_cnt); end
    wr = v && exp_rdy;
    rd = exp_vld && r;
    exp = '0;
    if (rd) begin
      c_rcv++;
      checks++;
      if (c_exp_q.size() == 0) begin
        errors++; $display("FAIL c_data: got %h expected none", {c_last_o, c_rdata});
      end else begin
        exp = c_exp_q.pop_front();
        if ({c_last_o, c_rdata} !== exp) begin errors++; $display("FAIL c_data: got %h expected %h", {c_last_o, c_rdata}, exp); end
      end
    end
    if (wr) c_exp_q.push_back({l, d});
    c_cnt  = c_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
    c_pcnt = c_pcnt + ((wr && l) ? 1 : 0) - ((rd && exp[8]) ? 1 : 0);
    @(posedge clk); #1;
    checks++;
    if (c_count !== 5'(c_cnt)) begin errors++; $display("FAIL c_count: got %0d expected %0d", c_count, c_cnt); end
    checks++;
    if (c_pkt !== 5'(c_pcnt)) begin errors++; $display("FAIL c_pkt_count: got %0d expected %0d", c_pkt, c_pcnt); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    a_cnt = 0; b_cnt = 0; c_cnt = 0; c_pcnt = 0;
    checks++;
    if ({a_ready_o, a_valid_o, a_ae, a_af} !== 4'b1010) begin
      errors++; $display("FAIL reset_flags: got rdy/vld/ae/af=%b expected 1010", {a_ready_o, a_valid_o, a_ae, a_af});
    end
    checks++;
    if (a_count !== 5'd0 || a_pkt !== 5'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", a_count, a_pkt); end
    checks++;
    if (b_valid_o !== 1'b0 || c_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_bc: got %b%b expected 00", b_valid_o, c_valid_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) begin
        checks++;
        if (a_af !== 1'b0) begin errors++; $display("FAIL fill_af13: got %b expected 0", a_af); end
      end
      if (i == 13) begin
        checks++;
        if (a_af !== 1'b1) begin errors++; $display("FAIL fill_af14: got %b expected 1", a_af); end
      end
    end
    checks++;
    if (a_ready_o !== 1'b0 || a_count !== 5'd16) begin
      errors++; $display("FAIL fill_full: got ready=%b count=%0d expected 0/16", a_ready_o, a_count);
    end
  endtask

  task automatic test_drain();
    // A write offered while full is refused even though a read happens in the same cycle.
    drive_a(1'b1, 8'hAA, 1'b0, 1'b1);
    checks++;
    if (a_count !== 5'd15) begin errors++; $display("FAIL full_no_bypass: got %0d expected 15", a_count); end
    for (int k = 0; k < 20 && a_cnt > 0; k++) drive_a(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (a_exp_q.size() != 0 || a_valid_o !== 1'b0 || a_ae !== 1'b1) begin
      errors++; $display("FAIL drain_end: got left=%0d valid=%b ae=%b expected 0/0/1", a_exp_q.size(), a_valid_o, a_ae);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 7; i++) drive_a(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    drive_a(1'b1, 8'h50, 1'b0, 1'b1);
    checks++;
    if (a_count !== 5'd7) begin errors++; $display("FAIL simul_count: got %0d expected 7", a_count); end
    drive_a(1'b1, 8'h51, 1'b1, 1'b0);
    drive_a(1'b1, 8'h52, 1'b0, 1'b0);
    checks++;
    if (a_count !== 5'd9) begin errors++; $display("FAIL pre_reset_count: got %0d expected 9", a_count); end
  endtask

  task automatic test_wrap();
    int sent;
    logic wr, v, r;
    sent = 0; b_rcv = 0;
    for (int cyc = 0; cyc < 400 && b_rcv < 12; cyc++) begin
      v = (sent < 12) && ($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      drive_b(v, 8'(sent * 7 + 3), (sent % 4) == 3, r, wr);
      if (wr) sent++;
    end
    b_wvalid = 1'b0; b_rready = 1'b0;
    checks++;
    if (b_rcv != 12 || b_exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_total: got received=%0d left=%0d expected 12/0", b_rcv, b_exp_q.size());
    end
  endtask

  task automatic test_packet();
    logic wr;
    c_rcv = 0;
    drive_c(1'b1, 8'h11, 1'b0, 1'b0, wr);
    drive_c(1'b1, 8'h22, 1'b0, 1'b0, wr);
    checks++;
    if (c_valid_o !== 1'b0) begin errors++; $display("FAIL pkt_hold: got valid=%b expected 0", c_valid_o); end
    drive_c(1'b1, 8'h33, 1'b1, 1'b0, wr);
    checks++;
    if (c_valid_o !== 1'b1 || c_pkt !== 5'd1) begin
      errors++; $display("FAIL pkt_release: got valid=%b pkt=%0d expected 1/1", c_valid_o, c_pkt);
    end
    for (int k = 0; k < 3; k++) drive_c(1'b0, 8'h00, 1'b0, 1'b1, wr);
    checks++;
    if (c_rcv != 3 || c_pkt !== 5'd0 || c_valid_o !== 1'b0) begin
      errors++; $display("FAIL pkt_done: got rcv=%0d pkt=%0d valid=%b expected 3/0/0", c_rcv, c_pkt, c_valid_o);
    end
  endtask

  task automatic test_long_packet();
    int sent, first_cnt;
    logic wr, seen;
    sent = 0; c_rcv = 0; seen = 1'b0; first_cnt = -1;
    for (int cyc = 0; cyc < 300 && c_rcv < 20; cyc++) begin
      if (!seen && c_valid_o === 1'b1) begin seen = 1'b1; first_cnt = int'(c_count); end
      drive_c(sent < 20, 8'(8'h80 + sent), sent == 19, 1'b1, wr);
      if (wr) sent++;
    end
    c_wvalid = 1'b0; c_rready = 1'b0;
    checks++;
    if (first_cnt != 16) begin errors++; $display("FAIL long_first_valid: got count %0d expected 16", first_cnt); end
    checks++;
    if (c_rcv != 20 || c_exp_q.size() != 0) begin
      errors++; $display("FAIL long_total: got received=%0d left=%0d expected 20/0", c_rcv, c_exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    a_wvalid = 1'b1; a_wdata = 8'hEE; a_wlast = 1'b0; a_rready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_wvalid = 1'b0; a_rready = 1'b0;
    a_exp_q.delete(); a_cnt = 0;
    checks++;
    if (a_count !== 5'd0 || a_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got count=%0d valid=%b ready=%b expected 0/0/1", a_count, a_valid_o, a_ready_o);
    end
    drive_a(1'b1, 8'h5C, 1'b1, 1'b0);
    drive_a(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (a_valid_o !== 1'b0 || a_exp_q.size() != 0) begin
      errors++; $display("FAIL stale_data: got valid=%b left=%0d expected 0/0", a_valid_o, a_exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    a_wdata = '0; a_wlast = 1'b0; a_wvalid = 1'b0; a_rready = 1'b0;
    b_wdata = '0; b_wlast = 1'b0; b_wvalid = 1'b0; b_rready = 1'b0;
    c_wdata = '0; c_wlast = 1'b0; c_wvalid = 1'b0; c_rready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_packet();
    test_long_packet();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
